// File: rtl/board_io_port_if.sv
// CPU-side load/store bus for board_io_port.
// Single-cycle request, response registered one cycle later.
interface board_io_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_be,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_be,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/board_io_port.sv
// Memory-mapped LED/switch port: LED, SW, EDGE (W1C) and ID registers.
// Define BOARD_IO_DEBOUNCE_EN to debounce switches with per-bit counters.
module board_io_port #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_8000,
  parameter int          DB_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  board_io_port_if.slave    bus,
  input  logic [15:0]       boardSwitches,
  output logic [15:0]       boardLEDs
);

  localparam logic [31:0] ID_VAL = 32'h4249_4F31;

  if (DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_bad
    $error("DB_CYCLES out of range");
  end

  logic        ready_q;
  logic        vld_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [15:0] led_q;
  logic [15:0] sync1_q;
  logic [15:0] sync2_q;
  logic [15:0] sw_q;
  logic [15:0] sw_nxt;
  logic [15:0] edge_q;
  logic [15:0] rise;
  logic [15:0] clr;
  logic [15:0] bmask;
  logic [31:0] off;
  logic [31:0] rd;
  logic        xfer;
  logic        err;
  logic        wr;
  logic        sel_led;
  logic        sel_sw;
  logic        sel_edge;
  logic        unused;

  assign off      = bus.req_addr - BASE_ADDR;
  assign xfer     = bus.req_valid & ready_q;
  assign err      = (off[31:4] != '0)
                  | (bus.req_addr[1:0] != 2'b00);
  assign wr       = xfer & bus.req_we & ~err;
  assign sel_led  = off[3:2] == 2'd0;
  assign sel_sw   = off[3:2] == 2'd1;
  assign sel_edge = off[3:2] == 2'd2;
  assign bmask    = {{8{bus.req_be[1]}},
                     {8{bus.req_be[0]}}};
  assign unused   = ^{bus.req_wdata[31:16],
                      bus.req_be[3:2], off[1:0]};

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign boardLEDs     = led_q;

`ifdef BOARD_IO_DEBOUNCE_EN
  logic [7:0] cnt_q   [16];
  logic [7:0] cnt_nxt [16];

  // Counter runs only while the synchronized bit disagrees with SW.
  always_comb begin
    sw_nxt = sw_q;
    for (int i = 0; i < 16; i++) begin
      cnt_nxt[i] = 8'd0;
      if (sync2_q[i] != sw_q[i]) begin
        if (cnt_q[i] == 8'(DB_CYCLES - 1))
          sw_nxt[i] = sync2_q[i];
        else
          cnt_nxt[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++)
        cnt_q[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 16; i++)
        cnt_q[i] <= cnt_nxt[i];
    end
  end
`else
  assign sw_nxt = sync2_q;
`endif

  assign rise = sw_nxt & ~sw_q;
  assign clr  = (wr && sel_edge)
              ? (bus.req_wdata[15:0] & bmask)
              : 16'h0;

  always_comb begin
    rd = ID_VAL;
    unique case (1'b1)
      sel_led:  rd = {16'h0, led_q};
      sel_sw:   rd = {16'h0, sw_q};
      sel_edge: rd = {16'h0, edge_q};
      default:  rd = ID_VAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      vld_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      led_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      sw_q    <= '0;
      edge_q  <= '0;
    end else begin
      ready_q <= 1'b1;
      vld_q   <= xfer;
      err_q   <= xfer & err;
      rdata_q <= (xfer && !bus.req_we && !err)
               ? rd : 32'h0;
      if (wr && sel_led) begin
        if (bus.req_be[0])
          led_q[7:0] <= bus.req_wdata[7:0];
        if (bus.req_be[1])
          led_q[15:8] <= bus.req_wdata[15:8];
      end
      sync1_q <= boardSwitches;
      sync2_q <= sync1_q;
      sw_q    <= sw_nxt;
      // A rise in the same cycle as a clear wins.
      edge_q  <= (edge_q & ~clr) | rise;
    end
  end

endmodule

// File: tb/tb_board_io_port.sv
// Directed self-checking bench for board_io_port.
// Latency expectations follow BOARD_IO_DEBOUNCE_EN.
module tb_board_io_port;
  localparam logic [31:0] BASE = 32'h0000_8000;
`ifdef BOARD_IO_DEBOUNCE_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = 16'h0;
  logic [15:0] leds;
  logic [31:0] rd;
  logic        er;
  int          total = 0;
  int          bad = 0;
  int          first;

  board_io_port_if bus();

  board_io_port dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .boardSwitches (sw),
    .boardLEDs     (leds)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; transfers on the next one.
  task automatic xfer(input logic        we,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  be);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    chk("rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    #12;
    chk("rst_ready", {31'b0, bus.req_ready}, 0);
    chk("rst_vld", {31'b0, bus.rsp_valid}, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_err", {31'b0, bus.rsp_err}, 0);
    chk("rst_leds", {16'h0, leds}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("ready_up", {31'b0, bus.req_ready}, 1);

    xfer(1, BASE, 32'h0000_A5C3, 4'b0011);
    chk("led_wr_leds", {16'h0, leds}, 32'h0000_A5C3);
    chk("led_wr_rd", rd, 0);
    chk("led_wr_err", {31'b0, er}, 0);
    xfer(0, BASE, 0, 0);
    chk("led_rd", rd, 32'h0000_A5C3);
    chk("led_rd_err", {31'b0, er}, 0);
    idle(1);
    chk("vld_drop", {31'b0, bus.rsp_valid}, 0);
    xfer(1, BASE, 32'hFFFF_FF00, 4'b0001);
    chk("led_be0", {16'h0, leds}, 32'h0000_A500);
    xfer(1, BASE, 32'hFFFF_FFFF, 4'b1100);
    chk("led_be32", {16'h0, leds}, 32'h0000_A500);

    xfer(0, BASE + 32'h10, 0, 0);
    chk("oor_err", {31'b0, er}, 1);
    chk("oor_rd", rd, 0);
    xfer(0, BASE + 32'h2, 0, 0);
    chk("mis_err", {31'b0, er}, 1);
    chk("mis_rd", rd, 0);
    xfer(1, BASE + 32'h2, 32'hFFFF, 4'b1111);
    chk("mis_wr_err", {31'b0, er}, 1);
    chk("mis_wr_leds", {16'h0, leds}, 32'h0000_A500);
    xfer(0, BASE - 32'h4, 0, 0);
    chk("low_err", {31'b0, er}, 1);
    xfer(0, BASE + 32'hC, 0, 0);
    chk("id_rd", rd, 32'h4249_4F31);
    chk("id_err", {31'b0, er}, 0);
    xfer(1, BASE + 32'hC, 0, 4'b1111);
    chk("id_wr_err", {31'b0, er}, 0);
    xfer(0, BASE + 32'hC, 0, 0);
    chk("id_keep", rd, 32'h4249_4F31);
    xfer(1, BASE + 32'h4, 32'hFFFF, 4'b1111);
    chk("sw_wr_err", {31'b0, er}, 0);
    xfer(0, BASE + 32'h4, 0, 0);
    chk("sw_keep", rd, 0);

    sw = 16'h0008;
    first = 0;
    for (int j = 1; j <= 14; j++) begin
      xfer(0, BASE + 32'h4, 0, 0);
      if (first == 0 && rd[3]) first = j;
    end
    chk("sw_latency", first, LAT + 1);
    xfer(0, BASE + 32'h8, 0, 0);
    chk("edge_set", rd, 32'h8);

`ifdef BOARD_IO_DEBOUNCE_EN
    sw = 16'h0020;
    idle(5);
    sw = 16'h0008;
    idle(LAT + 5);
    xfer(0, BASE + 32'h4, 0, 0);
    chk("glitch_sw", rd, 32'h8);
    xfer(0, BASE + 32'h8, 0, 0);
    chk("glitch_edge", rd, 32'h8);
`endif

    xfer(1, BASE + 32'h8, 32'h8, 4'b0011);
    xfer(0, BASE + 32'h8, 0, 0);
    chk("w1c", rd, 0);

    sw = 16'h0000;
    idle(LAT + 2);
    xfer(0, BASE + 32'h4, 0, 0);
    chk("sw_fall", rd, 0);
    xfer(0, BASE + 32'h8, 0, 0);
    chk("fall_noedge", rd, 0);
    sw = 16'h0008;
    idle(LAT - 1);
    xfer(1, BASE + 32'h8, 32'h8, 4'b0011);
    xfer(0, BASE + 32'h8, 0, 0);
    chk("set_wins", rd, 32'h8);
    xfer(1, BASE + 32'h8, 32'h8, 4'b0010);
    xfer(0, BASE + 32'h8, 0, 0);
    chk("w1c_be1", rd, 32'h8);
    xfer(1, BASE + 32'h8, 32'h8, 4'b0001);
    xfer(0, BASE + 32'h8, 0, 0);
    chk("w1c_be0", rd, 0);

    xfer(1, BASE, 32'h0000_FFFF, 4'b0011);
    chk("led_ffff", {16'h0, leds}, 32'h0000_FFFF);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = BASE;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("mid_vld", {31'b0, bus.rsp_valid}, 0);
    chk("mid_rdata", bus.rsp_rdata, 0);
    chk("mid_leds", {16'h0, leds}, 0);
    chk("mid_ready", {31'b0, bus.req_ready}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    chk("rel_ready", {31'b0, bus.req_ready}, 1);
    chk("rel_vld", {31'b0, bus.rsp_valid}, 0);
    xfer(0, BASE + 32'h8, 0, 0);
    chk("rel_edge0", rd, 0);
    idle(LAT + 2);
    xfer(0, BASE + 32'h8, 0, 0);
    chk("rel_edge1", rd, 32'h8);
    xfer(0, BASE + 32'h4, 0, 0);
    chk("rel_sw", rd, 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/board_io_port.md
BOARD_IO_PORT -- requirements
Module: board_io_port

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_8000, SHALL be the byte address of the 16-byte register window.
REQ-002 Parameter DB_CYCLES, default 8, range 2..255, SHALL be the number of consecutive stable cycles required to accept a switch change.
REQ-003 Port clk  input  1  SHALL be the single clock, rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-005 Port req_valid  input  1  SHALL signal a CPU load/store request.
REQ-006 Port req_ready  output  1  SHALL signal that the request is accepted.
REQ-007 Port req_we  input  1  SHALL select store (1) or load (0).
REQ-008 Port req_addr  input  32  SHALL carry the byte address.
REQ-009 Port req_wdata  input  32  SHALL carry the store data.
REQ-010 Port req_be  input  4  SHALL carry the store byte enables.
REQ-011 Port rsp_valid  output  1  SHALL mark a valid response.
REQ-012 Port rsp_rdata  output  32  SHALL carry load data, 0 for stores and errors.
REQ-013 Port rsp_err  output  1  SHALL flag a decode or alignment error.
REQ-014 Port boardSwitches  input  16  SHALL be the raw, asynchronous board switches.
REQ-015 Port boardLEDs  output  16  SHALL drive the board LEDs.

Function
REQ-016 Transfer SHALL occur on a cycle where req_valid and req_ready are both 1; req_ready SHALL be 1 on every cycle out of reset.
REQ-017 rsp_valid SHALL be 1 exactly one cycle after each transfer, lasting one cycle; back-to-back transfers SHALL give back-to-back responses.
REQ-018 Register map (offset from BASE_ADDR): 0x0 LED (RW, bits 15:0); 0x4 SW (RO, debounced switches); 0x8 EDGE (sticky rising-edge flags, write-1-to-clear); 0xC ID (RO, 32'h4249_4F31); upper 16 bits SHALL read 0 for 0x0..0x8.
REQ-019 Address outside [BASE_ADDR, BASE_ADDR+0xF] or req_addr[1:0]!=0 SHALL return rsp_err=1 and rsp_rdata=0, with no state change.
REQ-020 Stores to SW or ID SHALL be ignored with rsp_err=0.
REQ-021 LED stores SHALL honour req_be[0] (bits 7:0) and req_be[1] (bits 15:8); req_be[3:2] ignored; boardLEDs SHALL update the cycle after the transfer.
REQ-022 boardSwitches SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-023 Rising edge (0->1) of a debounced SW bit SHALL set the matching EDGE bit; a W1C store with req_be[1:0] applied SHALL clear set bits; same-cycle set and clear SHALL leave the bit set.
REQ-024 Load data SHALL reflect register state at the transfer cycle; a store followed by a load of the same register SHALL return the new value.

Reset
REQ-025 While rst_n=0: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, boardLEDs=0, and synchronizer, debounce, SW and EDGE state all 0.
REQ-026 Reset assertion mid-transfer SHALL drop the pending response; no EDGE bit SHALL set on the first cycles after reset from switches held high until the debounced value rises.

Configuration
REQ-027 With BOARD_IO_DEBOUNCE_EN defined: per bit, an 8-bit counter SHALL count cycles where the synchronized value differs from SW, reset to 0 when they match, and SW SHALL take the synchronized value when the count reaches DB_CYCLES-1.
REQ-028 Without BOARD_IO_DEBOUNCE_EN: SW SHALL equal the synchronized value delayed by one register stage, and DB_CYCLES SHALL be unused.

Verification
REQ-029 Store 0x0000_A5C3 with be=4'b0011 to BASE+0x0, then load BASE+0x0 -> boardLEDs=16'hA5C3 the cycle after the store; load returns 32'h0000_A5C3, rsp_err=0.
REQ-030 Store 0xFFFF_FF00 with be=4'b0001 over LED=16'hA5C3 -> boardLEDs=16'hA500.
REQ-031 Debounce on: switch bit 3 set to 1 and held -> SW bit 3 reads 1 after 2+DB_CYCLES (=10) cycles, not before; a 5-cycle glitch never changes SW; EDGE bit 3 becomes 1.
REQ-032 Store 0x0000_0008 to BASE+0x8 with EDGE=16'h0008 -> EDGE reads 0; repeat with a rising edge on bit 3 in the same cycle -> EDGE bit 3 stays 1.
REQ-033 Loads at BASE+0x10 and BASE+0x2 -> rsp_err=1, rsp_rdata=0, no register change; load BASE+0xC -> 32'h4249_4F31.
REQ-034 Assert rst_n=0 for one cycle mid-stream with LED=16'hFFFF -> boardLEDs=0 and rsp_valid=0 immediately; req_ready returns to 1 the first clock after release.
